// File: rtl/serial_to_parallel_if.sv
// rtl/serial_to_parallel_if.sv - word output valid/ready bundle for serial_to_parallel
interface serial_to_parallel_if #(
  parameter int DATA_SIZE = 64
);
  logic [DATA_SIZE-1:0] data_out;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - LSB-first bit deserializer with one-word holding register
module serial_to_parallel #(
  parameter int DATA_SIZE = 64,
  localparam int CW = $clog2(DATA_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    clear,
  serial_to_parallel_if.master    bus,
  output logic [CW-1:0]           bit_count,
  output logic                    overrun
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, next_state;

  // Bit 0 of the shift register would be pushed out by the next shift or
  // replaced at completion, so only the upper DATA_SIZE-1 bits are kept.
  logic [DATA_SIZE-1:1] sr;
  logic [DATA_SIZE-1:0] new_word;
  logic                 accept;
  logic                 complete;
  logic                 handshake;
  logic                 load;
  logic                 drop;

  // clear wins over bit_valid, so a bit presented with clear never counts.
  assign accept    = bit_valid & ~clear;
  assign complete  = accept & (bit_count == CW'(DATA_SIZE - 1));
  assign new_word  = {bit_in, sr};
  assign handshake = (state == FULL) & bus.out_ready;
  assign bus.out_valid = (state == FULL);

  // Shift register and partial-word bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
    end else if (accept) begin
      sr <= new_word[DATA_SIZE-1:1];
      if (complete) begin
        bit_count <= '0;
      end else begin
        bit_count <= bit_count + CW'(1);
      end
    end
  end

  // Holding state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Holding next-state: load on completion when the slot is free or draining,
  // otherwise drop the new word and report it
  always_comb begin
    next_state = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          next_state = FULL;
        end
      end
      FULL: begin
        if (complete && handshake) begin
          load = 1'b1;
        end else if (complete) begin
          drop = 1'b1;
        end else if (handshake) begin
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Held output word; only changes when a completed word is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= '0;
    end else if (load) begin
      bus.data_out <= new_word;
    end
  end

  // Sticky overrun flag, cleared only by reset or clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - randomized self-checking bench for serial_to_parallel
module tb_serial_to_parallel;
  localparam int DS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] bit_count;
  logic       overrun;

  serial_to_parallel_if #(.DATA_SIZE(DS)) bus ();

  serial_to_parallel #(.DATA_SIZE(DS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .bus       (bus),
    .bit_count (bit_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: bits gathered as an integer, a word slot and a flag
  int          m_cnt = 0;
  int unsigned m_partial = 0;
  int unsigned m_hold = 0;
  bit          m_valid = 1'b0;
  bit          m_ovr = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit          hs;
    bit          comp;
    int unsigned w;
    comp = 1'b0;
    w    = 0;
    if (rst) begin
      m_cnt = 0; m_partial = 0; m_hold = 0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      hs = m_valid && bus.out_ready;
      if (clear) begin
        m_cnt = 0; m_partial = 0; m_ovr = 1'b0;
      end else if (bit_valid) begin
        m_partial = m_partial + (int'(bit_in) << m_cnt);
        m_cnt++;
        if (m_cnt == DS) begin
          comp = 1'b1; w = m_partial; m_partial = 0; m_cnt = 0;
        end
      end
      if (comp) begin
        if (!m_valid || hs) begin
          m_hold = w; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_out_valid", longint'(bus.out_valid), longint'(m_valid));
      chk("cmp_bit_count", longint'(bit_count), longint'(m_cnt));
      chk("cmp_overrun", longint'(overrun), longint'(m_ovr));
      if (m_valid) chk("cmp_data_out", longint'(bus.data_out), longint'(m_hold));
    end
  end

  task automatic step(input logic b, input logic v, input logic r, input logic c);
    @(negedge clk);
    bit_in = b; bit_valid = v; bus.out_ready = r; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ready_last);
    for (int i = 0; i < DS; i++) step(d[i], 1'b1, (i == DS - 1) ? ready_last : 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    bus.out_ready = 1'b0;
    pat = 8'h4D;

    // reset with bit_valid high
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_out_valid", longint'(bus.out_valid), 0);
    chk("reset_bit_count", longint'(bit_count), 0);
    chk("reset_overrun", longint'(overrun), 0);
    chk("reset_data_out", longint'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    check_en = 1'b1;

    // single word 1,0,1,1,0,0,1,0
    send_byte(pat, 1'b0);
    chk("single_valid", longint'(bus.out_valid), 1);
    chk("single_data", longint'(bus.data_out), 64'h4D);
    chk("model_single", longint'(m_hold), 64'h4D);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("single_drained", longint'(bus.out_valid), 0);

    // gapped stream
    for (int i = 0; i < DS; i++) begin
      chk("gap_bit_count", longint'(bit_count), longint'(i));
      step(pat[i], 1'b1, 1'b0, 1'b0);
      step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
    end
    chk("gap_data", longint'(bus.data_out), 64'h4D);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // back-pressure
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("bp_data_held", longint'(bus.data_out), 64'hA5);
    chk("bp_overrun", longint'(overrun), 1);
    send_byte(8'h0F, 1'b1);
    chk("bp_new_data", longint'(bus.data_out), 64'h0F);
    chk("bp_valid", longint'(bus.out_valid), 1);
    chk("bp_overrun_sticky", longint'(overrun), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_clear_overrun", longint'(overrun), 0);

    // simultaneous drain and complete
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    chk("sim_data", longint'(bus.data_out), 64'h22);
    chk("sim_valid", longint'(bus.out_valid), 1);
    chk("sim_overrun", longint'(overrun), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // clear mid-word with a held word
    send_byte(8'h99, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_pre_count", longint'(bit_count), 5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_count", longint'(bit_count), 0);
    chk("clr_hold_valid", longint'(bus.out_valid), 1);
    chk("clr_hold_data", longint'(bus.data_out), 64'h99);
    send_byte(8'hFF, 1'b1);
    chk("clr_word", longint'(bus.data_out), 64'hFF);
    chk("clr_word_valid", longint'(bus.out_valid), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      bit_in        = 1'($urandom_range(1));
      bit_valid     = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) == 0);
      clear         = ($urandom_range(49) == 0);
      rst           = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0; clear = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
